// File: rtl/pe_namespace_loader.sv
// ---------------------------------------------------------------------------
// pe_namespace_loader
//
// Write-side initiator for one PE namespace. A valid/ready word stream carries
// packets made of one header word followed by `count` payload words. The
// header selects the target namespace, its start address and the payload
// length. Every accepted payload word becomes a registered write into that
// namespace one cycle later. Instruction pushes are throttled by
// inst_fifo_full and never issued in two consecutive cycles.
//
// Header layout (dataLen bits):
//   [dataLen-1:dataLen-2] namespace (0 inst, 1 data, 2 weight, 3 meta)
//   [cntLen+5:cntLen]     base address (unused for inst)
//   [cntLen-1:0]          payload word count
//
// Ports:
//   clk, reset           single clock, synchronous active-low reset
//   in_valid/in_data     stream word input, accepted on in_valid & in_ready
//   in_ready             stream ready (combinational; 0 while reset is low)
//   inst_fifo_full       instruction FIFO backpressure
//   inst_wrt/inst_in     instruction FIFO push and word
//   data_*/weight_*/meta_*  write enable, address and value per memory
//   busy                 high while payload words are still outstanding
//   done                 one-cycle pulse with the last write of a packet,
//                        or one cycle after a zero-count header
// ---------------------------------------------------------------------------
module pe_namespace_loader #(
   parameter int dataLen       = 32,
   parameter int instLen       = 32,
   parameter int dataAddrLen   = 6,
   parameter int weightAddrLen = 6,
   parameter int metaAddrLen   = 2,
   parameter int cntLen        = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   input  logic [dataLen-1:0]       in_data,
   output logic                     in_ready,
   input  logic                     inst_fifo_full,
   output logic                     inst_wrt,
   output logic [instLen-1:0]       inst_in,
   output logic                     data_wrt,
   output logic [dataAddrLen-1:0]   data_wrt_addr,
   output logic [dataLen-1:0]       data_in,
   output logic                     weight_wrt,
   output logic [weightAddrLen-1:0] weight_wrt_addr,
   output logic [dataLen-1:0]       weight_in,
   output logic                     meta_wrt,
   output logic [metaAddrLen-1:0]   meta_wrt_addr,
   output logic [dataLen-1:0]       meta_in,
   output logic                     busy,
   output logic                     done
);

   localparam int BASE_W = 6;
   localparam int MAX_A1 = (dataAddrLen > weightAddrLen) ? dataAddrLen : weightAddrLen;
   localparam int MAX_A2 = (MAX_A1 > metaAddrLen) ? MAX_A1 : metaAddrLen;
   // Address counter is wide enough for the widest target; each output port
   // takes only its low bits, so wrap-around per namespace comes for free.
   localparam int ADDR_W = (MAX_A2 > BASE_W) ? MAX_A2 : BASE_W;

   localparam logic [1:0] NS_INST   = 2'd0;
   localparam logic [1:0] NS_DATA   = 2'd1;
   localparam logic [1:0] NS_WEIGHT = 2'd2;
   localparam logic [1:0] NS_META   = 2'd3;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_LOAD = 1'b1
   } state_t;

   state_t              state_r;
   state_t              state_nxt_s;
   logic [1:0]          ns_r;
   logic [ADDR_W-1:0]   addr_r;
   logic [cntLen-1:0]   remaining_r;

   logic [1:0]          hdr_ns_s;
   logic [BASE_W-1:0]   hdr_base_s;
   logic [cntLen-1:0]   hdr_cnt_s;
   logic                hdr_empty_s;
   logic                ready_s;
   logic                accept_s;
   logic                last_beat_s;

   assign in_ready = ready_s;

   // Header field decode of the current stream word
   always_comb begin
      hdr_ns_s    = in_data[dataLen-1 -: 2];
      hdr_base_s  = in_data[cntLen+BASE_W-1 : cntLen];
      hdr_cnt_s   = in_data[cntLen-1:0];
      hdr_empty_s = (hdr_cnt_s == {cntLen{1'b0}});
   end

   // Stream ready and handshake. In an instruction packet a push in the
   // previous cycle blocks acceptance, giving at most one push per two cycles.
   always_comb begin
      ready_s = 1'b0;
      if (!reset) begin
         ready_s = 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: ready_s = 1'b1;
            ST_LOAD: begin
               if (ns_r == NS_INST) begin
                  ready_s = !inst_fifo_full && !inst_wrt;
               end else begin
                  ready_s = 1'b1;
               end
            end
            default: ready_s = 1'b0;
         endcase
      end
      accept_s    = in_valid && ready_s;
      last_beat_s = (remaining_r == cntLen'(1));
   end

   // Next-state logic
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s && !hdr_empty_s) begin
               state_nxt_s = ST_LOAD;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_LOAD: begin
            if (accept_s && last_beat_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_LOAD;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Packet context, registered write outputs, busy and done
   always_ff @(posedge clk) begin
      if (!reset) begin
         ns_r            <= NS_INST;
         addr_r          <= {ADDR_W{1'b0}};
         remaining_r     <= {cntLen{1'b0}};
         inst_wrt        <= 1'b0;
         inst_in         <= {instLen{1'b0}};
         data_wrt        <= 1'b0;
         data_wrt_addr   <= {dataAddrLen{1'b0}};
         data_in         <= {dataLen{1'b0}};
         weight_wrt      <= 1'b0;
         weight_wrt_addr <= {weightAddrLen{1'b0}};
         weight_in       <= {dataLen{1'b0}};
         meta_wrt        <= 1'b0;
         meta_wrt_addr   <= {metaAddrLen{1'b0}};
         meta_in         <= {dataLen{1'b0}};
         busy            <= 1'b0;
         done            <= 1'b0;
      end else begin
         // Strobes and done are single-cycle; address/data outputs hold.
         inst_wrt   <= 1'b0;
         data_wrt   <= 1'b0;
         weight_wrt <= 1'b0;
         meta_wrt   <= 1'b0;
         done       <= 1'b0;
         busy       <= (state_nxt_s == ST_LOAD);
         if (accept_s) begin
            if (state_r == ST_IDLE) begin
               ns_r        <= hdr_ns_s;
               addr_r      <= ADDR_W'(hdr_base_s);
               remaining_r <= hdr_cnt_s;
               done        <= hdr_empty_s;
            end else begin
               case (ns_r)
                  NS_INST: begin
                     inst_wrt <= 1'b1;
                     inst_in  <= in_data[instLen-1:0];
                  end
                  NS_DATA: begin
                     data_wrt      <= 1'b1;
                     data_wrt_addr <= addr_r[dataAddrLen-1:0];
                     data_in       <= in_data;
                  end
                  NS_WEIGHT: begin
                     weight_wrt      <= 1'b1;
                     weight_wrt_addr <= addr_r[weightAddrLen-1:0];
                     weight_in       <= in_data;
                  end
                  NS_META: begin
                     meta_wrt      <= 1'b1;
                     meta_wrt_addr <= addr_r[metaAddrLen-1:0];
                     meta_in       <= in_data;
                  end
                  default: begin
                     inst_wrt <= 1'b0;
                  end
               endcase
               addr_r      <= addr_r + ADDR_W'(1);
               remaining_r <= remaining_r - cntLen'(1);
               done        <= last_beat_s;
            end
         end
      end
   end

endmodule
